// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// MULDIV_DIV_EN adds the divide-only fields to the captured op context.
package muldiv_pkg;

    localparam int          MULDIV_ITER = 32;
    localparam logic [31:0] DIV0_QUOT   = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX
    } state_e;

    // Sign fix-up decided at launch so the FIX cycle needs no operand signs.
    typedef struct packed {
        logic is_div;
        logic neg_res;
`ifdef MULDIV_DIV_EN
        logic neg_rem;
`endif
    } ctx_t;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute-stage controller and muldiv_unit.
interface muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, hi_we, lo_we, wdata,
                    input  busy, done, div0, hi, lo);
    modport slave  (input  start, op, a, b, hi_we, lo_we, wdata,
                    output busy, done, div0, hi, lo);
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: right-shift-add multiply or restoring divide.
// The divide path exists only with MULDIV_DIV_EN.
module muldiv_step (
    input  logic [63:0] acc,
    input  logic [31:0] opnd,
    input  logic        is_div,
    output logic [63:0] acc_next
);
    // Multiply: acc = {partial product, remaining multiplier bits}.
    logic [32:0] sum;
    assign sum = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd : 32'd0)};

`ifdef MULDIV_DIV_EN
    // Divide: acc = {remainder, dividend bits shifting into quotient bits}.
    logic [32:0] rem_sh;
    logic [31:0] diff;
    logic        fits;
    assign rem_sh = {acc[63:32], acc[31]};
    assign fits   = (rem_sh >= {1'b0, opnd});
    assign diff   = rem_sh[31:0] - opnd;

    always_comb begin
        if (!is_div)   acc_next = {sum, acc[31:1]};
        else if (fits) acc_next = {diff, acc[30:0], 1'b1};
        else           acc_next = {rem_sh[31:0], acc[30:0], 1'b0};
    end
`else
    assign acc_next = is_div ? acc : {sum, acc[31:1]};
`endif

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU with architectural HI/LO, 33-cycle latency.
// MULDIV_DIV_EN enables the divide ops; without it divide starts are ignored.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    muldiv_if.slave bus
);
    state_e      state, state_nxt;
    logic [5:0]  count;
    logic [63:0] acc, acc_step, prod_fix;
    logic [31:0] opnd, hi_q, lo_q, hi_res, lo_res;
    logic        done_q, busy, launch, last_iter, op_sgn, op_div;
    ctx_t        ctx;

    assign op_sgn = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign op_div = (bus.op == OP_DIVU) || (bus.op == OP_DIV);
`ifdef MULDIV_DIV_EN
    logic [31:0] a_q;
    logic        div0_q;
    assign launch = bus.start;
`else
    assign launch = bus.start && !op_div;
`endif
    assign last_iter = (count == 6'(MULDIV_ITER - 1));

    muldiv_step u_step (
        .acc      (acc),
        .opnd     (opnd),
        .is_div   (ctx.is_div),
        .acc_next (acc_step)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (launch)    state_nxt = ST_RUN;
            ST_RUN:  if (last_iter) state_nxt = ST_FIX;
            ST_FIX:                 state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
    end

    // Final sign correction; divide-by-zero bypasses the iterated result.
    always_comb begin
        prod_fix = ctx.neg_res ? (64'd0 - acc) : acc;
        hi_res   = prod_fix[63:32];
        lo_res   = prod_fix[31:0];
`ifdef MULDIV_DIV_EN
        if (ctx.is_div) begin
            if (opnd == 32'd0) begin
                lo_res = DIV0_QUOT;
                hi_res = a_q;
            end else begin
                lo_res = ctx.neg_res ? (32'd0 - acc[31:0])  : acc[31:0];
                hi_res = ctx.neg_rem ? (32'd0 - acc[63:32]) : acc[63:32];
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            acc    <= '0;
            opnd   <= '0;
            ctx    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
`ifdef MULDIV_DIV_EN
            a_q    <= '0;
            div0_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef MULDIV_DIV_EN
            div0_q <= 1'b0;
`endif
            unique case (state)
                ST_IDLE: begin
                    if (bus.hi_we) hi_q <= bus.wdata;
                    if (bus.lo_we) lo_q <= bus.wdata;
                    if (launch) begin
                        count       <= '0;
                        ctx.is_div  <= op_div;
                        ctx.neg_res <= op_sgn & (bus.a[31] ^ bus.b[31]);
`ifdef MULDIV_DIV_EN
                        ctx.neg_rem <= op_sgn & bus.a[31];
                        a_q         <= bus.a;
`endif
                        if (op_div) begin
                            acc  <= {32'd0, abs32(bus.a, op_sgn & bus.a[31])};
                            opnd <= abs32(bus.b, op_sgn & bus.b[31]);
                        end else begin
                            acc  <= {32'd0, abs32(bus.b, op_sgn & bus.b[31])};
                            opnd <= abs32(bus.a, op_sgn & bus.a[31]);
                        end
                    end
                end
                ST_RUN: begin
                    acc   <= acc_step;
                    count <= count + 6'd1;
                end
                ST_FIX: begin
                    hi_q   <= hi_res;
                    lo_q   <= lo_res;
                    done_q <= 1'b1;
`ifdef MULDIV_DIV_EN
                    div0_q <= ctx.is_div && (opnd == 32'd0);
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
`ifdef MULDIV_DIV_EN
    assign bus.div0 = div0_q;
`else
    assign bus.div0 = 1'b0;
`endif

endmodule
